// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single memory bus between the front-end instruction fetch and the
// execute-stage data load/store port.
//
// Arbitration: data accesses normally win. While a fetch is waiting, every
// data grant bumps a saturating streak counter. Once the streak reaches
// MAX_DM_STREAK, the fetch wins the next contested slot. This guarantees that
// fetch makes progress under continuous data traffic.
//
// Flush: a PC redirect (if_flush) cannot abort a fetch that is already on the
// bus. That fetch runs to completion, but its result is dropped and no if_rdy
// pulse is produced.
//
// Optional build macro: MEM_ARB_PERF_EN
//   When defined, adds two 16-bit wrapping performance counters:
//     perf_if_stall - cycles in which a live fetch request waits
//     perf_dm_grant - number of data grants
//
// Ports
//   clk        in   1   clock
//   a_rst      in   1   synchronous active-high reset
//   if_req     in   1   fetch request, held with if_addr until if_rdy/if_flush
//   if_addr    in  16   fetch address
//   if_flush   in   1   PC redirect, cancels the current or pending fetch
//   if_rdata   out 32   fetched word, valid with if_rdy
//   if_rdy     out  1   one-cycle fetch completion pulse
//   dm_req     in   1   data request, held with its controls until dm_rdy
//   dm_we      in   1   1 = write, 0 = read
//   dm_addr    in  16   data address
//   dm_wdata   in   8   write byte
//   dm_rdata   out  8   read byte, valid with dm_rdy
//   dm_rdy     out  1   one-cycle data completion pulse
//   mem_req    out  1   bus request, held until mem_ack
//   mem_we     out  1   bus write enable
//   mem_addr   out 16   bus address
//   mem_wdata  out  8   bus write byte
//   mem_rdata  in  32   bus read word
//   mem_ack    in   1   bus completion, only meaningful while mem_req = 1
//   perf_if_stall out 16  (MEM_ARB_PERF_EN only) fetch stall cycle count
//   perf_dm_grant out 16  (MEM_ARB_PERF_EN only) data grant count
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MAX_DM_STREAK = 4  // legal range 1..255
) (
  input  logic        clk,
  input  logic        a_rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_rdy,
  // data port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [7:0]  dm_wdata,
  output logic [7:0]  dm_rdata,
  output logic        dm_rdy,
  // memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0] perf_if_stall,
  output logic [15:0] perf_dm_grant
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [7:0] MAX_STREAK = 8'(MAX_DM_STREAK);

  state_t      state_reg, state_next;

  logic        mem_req_reg,   mem_req_next;
  logic        mem_we_reg,    mem_we_next;
  logic [15:0] mem_addr_reg,  mem_addr_next;
  logic [7:0]  mem_wdata_reg, mem_wdata_next;

  logic        if_rdy_reg,    if_rdy_next;
  logic [31:0] if_rdata_reg,  if_rdata_next;
  logic        dm_rdy_reg,    dm_rdy_next;
  logic [7:0]  dm_rdata_reg,  dm_rdata_next;

  logic [7:0]  streak_reg,    streak_next;
  logic        discard_reg,   discard_next;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_if_stall_reg, perf_if_stall_next;
  logic [15:0] perf_dm_grant_reg, perf_dm_grant_next;
`endif

  // Arbitration helpers, all driven from the next-state process.
  logic        if_elig;
  logic        dm_elig;
  logic        grant_if;
  logic        grant_dm;
  logic        bus_ack;
  logic        streak_full;

  // ---------------------------------------------------------------------------
  // State register: FSM state plus every registered output and counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (a_rst) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdy_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdy_reg    <= 1'b0;
      dm_rdata_reg  <= '0;
      streak_reg    <= '0;
      discard_reg   <= 1'b0;
`ifdef MEM_ARB_PERF_EN
      perf_if_stall_reg <= '0;
      perf_dm_grant_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdy_reg    <= if_rdy_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdy_reg    <= dm_rdy_next;
      dm_rdata_reg  <= dm_rdata_next;
      streak_reg    <= streak_next;
      discard_reg   <= discard_next;
`ifdef MEM_ARB_PERF_EN
      perf_if_stall_reg <= perf_if_stall_next;
      perf_dm_grant_reg <= perf_dm_grant_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdy_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    dm_rdy_next    = 1'b0;
    dm_rdata_next  = dm_rdata_reg;
    streak_next    = streak_reg;
    discard_next   = discard_reg;

    // A requester whose rdy is high is still presenting the transaction that
    // just finished. Its request is ignored for this cycle so the same
    // access is not issued twice.
    if_elig     = if_req & ~if_flush & ~if_rdy_reg;
    dm_elig     = dm_req & ~dm_rdy_reg;
    streak_full = (streak_reg >= MAX_STREAK);
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    // Ack is meaningful only against an outstanding request.
    bus_ack     = mem_ack & mem_req_reg;

    case (state_reg)
      IDLE: begin
        grant_if = if_elig & (~dm_elig | streak_full);
        grant_dm = dm_elig & ~grant_if;

        if (grant_if) begin
          state_next     = BUSY_IF;
          mem_req_next   = 1'b1;
          mem_addr_next  = if_addr;
          mem_we_next    = 1'b0;
          mem_wdata_next = '0;
          streak_next    = '0;
        end else if (grant_dm) begin
          state_next     = BUSY_DM;
          mem_req_next   = 1'b1;
          mem_addr_next  = dm_addr;
          mem_we_next    = dm_we;
          mem_wdata_next = dm_wdata;
          // Count only the data grants that actually made a fetch wait.
          if (if_req) begin
            streak_next = streak_full ? streak_reg : streak_reg + 8'd1;
          end else begin
            streak_next = '0;
          end
        end else if (!if_req) begin
          streak_next = '0;
        end
      end

      BUSY_IF: begin
        if (if_flush) begin
          discard_next = 1'b1;
        end
        if (bus_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          // A flush in the ack cycle counts as well as an earlier one.
          if (discard_reg || if_flush) begin
            discard_next = 1'b0;
          end else begin
            if_rdy_next   = 1'b1;
            if_rdata_next = mem_rdata;
          end
        end
      end

      BUSY_DM: begin
        if (bus_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          dm_rdy_next  = 1'b1;
          // Writes leave the last read byte visible.
          if (!mem_we_reg) begin
            dm_rdata_next = mem_rdata[7:0];
          end
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase

`ifdef MEM_ARB_PERF_EN
    perf_if_stall_next = perf_if_stall_reg;
    perf_dm_grant_next = perf_dm_grant_reg;
    // A live fetch request waits if it is neither on the bus nor granted now.
    if (if_req && !if_flush && (state_reg != BUSY_IF) && !grant_if) begin
      perf_if_stall_next = perf_if_stall_reg + 16'd1;
    end
    if (grant_dm) begin
      perf_dm_grant_next = perf_dm_grant_reg + 16'd1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs: all ports come straight from registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req   = mem_req_reg;
    mem_we    = mem_we_reg;
    mem_addr  = mem_addr_reg;
    mem_wdata = mem_wdata_reg;
    if_rdy    = if_rdy_reg;
    if_rdata  = if_rdata_reg;
    dm_rdy    = dm_rdy_reg;
    dm_rdata  = dm_rdata_reg;
`ifdef MEM_ARB_PERF_EN
    perf_if_stall = perf_if_stall_reg;
    perf_dm_grant = perf_dm_grant_reg;
`endif
  end

endmodule
